// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Operation codes and the divide sequencer states.
package hilo_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    MTHI = 3'd1,
    MTLO = 3'd2,
    MULT = 3'd3,
    MADD = 3'd4,
    MSUB = 3'd5,
    DIV  = 3'd6
  } hilo_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } hilo_state_t;

endpackage

// File: rtl/hilo_div_iter.sv
// Unsigned W-bit restoring divider, one quotient bit per cycle.
// start_i loads operands; done_o flags the final step; abort_i cancels.
module hilo_div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  r_q;
  logic [W-1:0]  d_q;

  logic [W:0]    sh;
  logic          ge;
  logic [W-1:0]  r_d;
  logic [W-1:0]  q_d;

  // Shift the next dividend bit into the partial remainder and try
  // subtracting; the trial never exceeds W bits once it succeeds.
  assign sh  = {r_q, q_q[W-1]};
  assign ge  = sh >= {1'b0, d_q};
  assign r_d = ge ? (sh[W-1:0] - d_q) : sh[W-1:0];
  assign q_d = {q_q[W-2:0], ge};

  // Results are the outcome of the step taken on the done edge.
  assign done_o = run_q && (cnt_q == LAST);
  assign quot_o = q_d;
  assign rem_o  = r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      q_q   <= dividend_i;
      r_q   <= '0;
      d_q   <= divisor_i;
    end else if (run_q) begin
      if (abort_i) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        q_q   <= q_d;
        r_q   <= r_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          run_q <= 1'b0;
          cnt_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle move/mul/madd/msub and a
// background W-cycle divide. Outputs: busy_o, hi_o, lo_o (registered).
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [2:0]   op_i,
  input  logic         signed_i,
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         stall_i,
  input  logic         flush_i,
  output logic         busy_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  hilo_state_t  state_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic         qneg_q;
  logic         rneg_q;
  logic         dz_q;
  logic         ov_q;
  logic [W-1:0] a_q;

  hilo_op_t     op;
  logic         accept;
  logic         div_go;
  logic [2*W-1:0] ext_a;
  logic [2*W-1:0] ext_b;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] acc;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;
  logic         dv_done;
  logic [W-1:0] dv_quot;
  logic [W-1:0] dv_rem;

  assign op     = hilo_op_t'(op_i);
  assign busy_o = (state_q == RUN);
  assign accept = valid_i & ~stall_i & ~flush_i & ~busy_o;
  assign div_go = accept && (op == DIV);

  assign a_neg = signed_i & src_a[W-1];
  assign b_neg = signed_i & src_b[W-1];

  // Low 2W bits of the extended product are exact in both modes.
  assign ext_a = {{W{a_neg}}, src_a};
  assign ext_b = {{W{b_neg}}, src_b};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi_q, lo_q};

  assign mag_a = a_neg ? (~src_a + 1'b1) : src_a;
  assign mag_b = b_neg ? (~src_b + 1'b1) : src_b;

  hilo_div_iter #(.W(W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_go),
    .abort_i    (flush_i),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (dv_done),
    .quot_o     (dv_quot),
    .rem_o      (dv_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      a_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (op)
              MTHI: hi_q <= src_a;
              MTLO: lo_q <= src_a;
              MULT: {hi_q, lo_q} <= prod;
              MADD: {hi_q, lo_q} <= acc + prod;
              MSUB: {hi_q, lo_q} <= acc - prod;
              DIV: begin
                state_q <= RUN;
                qneg_q  <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
                dz_q    <= (src_b == '0);
                ov_q    <= signed_i && (src_a == MIN_NEG)
                           && (src_b == '1);
                a_q     <= src_a;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else if (dv_done) begin
            state_q <= IDLE;
            if (dz_q) begin
              lo_q <= '1;
              hi_q <= a_q;
            end else if (ov_q) begin
              lo_q <= MIN_NEG;
              hi_q <= '0;
            end else begin
              lo_q <= qneg_q ? (~dv_quot + 1'b1) : dv_quot;
              hi_q <= rneg_q ? (~dv_rem + 1'b1) : dv_rem;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
